dmem_arbiter: RTL and testbench

- Shares the single-port dmem syncram between two requesters.
  - Port 0: processor load/store path.
  - Port 1: debug/loader engine that preloads or inspects data memory.
- Sits between the requesters and the dmem instance.
- Arbitrates round-robin, registers the dmem address, data and wren outputs, and tracks the syncram read latency.
- Returns read data to the port that issued the read.

---
 rtl/dmem_arbiter_if.sv | 30 +++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for dmem_arbiter: two request ports plus the shared,
// rvalid-qualified read data returned to them.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_0;
  logic              req_1;
  logic              we_0;
  logic              we_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_0;
  logic [DATA_W-1:0] wdata_1;
  logic              gnt_0;
  logic              gnt_1;
  logic              rvalid_0;
  logic              rvalid_1;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
    input  gnt_0, gnt_1, rvalid_0, rvalid_1, rdata
  );

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
    output gnt_0, gnt_1, rvalid_0, rvalid_1, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port dmem syncram between the processor (port 0) and the debug/loader
// engine (port 1). Round-robin by default; define DMEM_ARB_FIXED_PRIO_EN for fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int               CNT_W = 3;
  localparam logic [CNT_W-1:0] LAT   = CNT_W'(READ_LATENCY);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             owner;
  logic             gnt_0_q;
  logic             gnt_1_q;
  logic             rvalid_0_q;
  logic             rvalid_1_q;
  logic [DATA_W-1:0] rdata_q;
  logic             any_req;
  logic             winner;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic             last_gnt;
`endif

  assign any_req = bus.req_0 | bus.req_1;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
  always_comb begin
    winner = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    winner = ~bus.req_0;
`else
    // On a tie the port that did not win last time goes first.
    if (bus.req_0 && bus.req_1) winner = ~last_gnt;
    else                        winner = bus.req_1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      owner        <= 1'b0;
      gnt_0_q      <= 1'b0;
      gnt_1_q      <= 1'b0;
      rvalid_0_q   <= 1'b0;
      rvalid_1_q   <= 1'b0;
      rdata_q      <= '0;
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_gnt     <= 1'b1;
`endif
    end else begin
      // Grant, rvalid and wren are single-cycle pulses; the cases below raise them.
      gnt_0_q    <= 1'b0;
      gnt_1_q    <= 1'b0;
      rvalid_0_q <= 1'b0;
      rvalid_1_q <= 1'b0;
      wren       <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= winner;
            address_dmem <= winner ? bus.addr_1  : bus.addr_0;
            data         <= winner ? bus.wdata_1 : bus.wdata_0;
            wren         <= winner ? bus.we_1    : bus.we_0;
            gnt_0_q      <= ~winner;
            gnt_1_q      <= winner;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_gnt     <= winner;
`endif
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          // wren still carries the winner's we during this cycle.
          if (wren) begin
            state <= IDLE;
          end else begin
            wait_cnt <= LAT;
            state    <= WAIT;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == CNT_W'(1)) begin
            rdata_q    <= q_dmem;
            rvalid_0_q <= ~owner;
            rvalid_1_q <= owner;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_0    = gnt_0_q;
  assign bus.gnt_1    = gnt_1_q;
  assign bus.rvalid_0 = rvalid_0_q;
  assign bus.rvalid_1 = rvalid_1_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: two instances (READ_LATENCY 1 and 3) share one stimulus
// script and are scored against a transaction-level timing model with its own memory image.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int ND     = 2;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Requester-side stimulus and observed outputs, indexed [dut][port].
  logic              req_v   [ND][2];
  logic              we_v    [ND][2];
  logic [ADDR_W-1:0] addr_v  [ND][2];
  logic [DATA_W-1:0] wdata_v [ND][2];
  logic              gnt_v   [ND][2];
  logic              rvalid_v[ND][2];
  logic [DATA_W-1:0] rdata_v [ND];
  logic [ADDR_W-1:0] adm_v   [ND];
  logic [DATA_W-1:0] dat_v   [ND];
  logic              wren_v  [ND];

  logic [ADDR_W-1:0] adm_a, adm_b;
  logic [DATA_W-1:0] dat_a, dat_b;
  logic              wren_a, wren_b;
  logic [DATA_W-1:0] q_a, q_b;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) u_dut_a (
    .clock(clock), .reset(reset), .bus(bus_a),
    .address_dmem(adm_a), .data(dat_a), .wren(wren_a), .q_dmem(q_a)
  );

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(3)) u_dut_b (
    .clock(clock), .reset(reset), .bus(bus_b),
    .address_dmem(adm_b), .data(dat_b), .wren(wren_b), .q_dmem(q_b)
  );

  assign bus_a.req_0 = req_v[0][0];   assign bus_a.req_1 = req_v[0][1];
  assign bus_a.we_0  = we_v[0][0];    assign bus_a.we_1  = we_v[0][1];
  assign bus_a.addr_0 = addr_v[0][0]; assign bus_a.addr_1 = addr_v[0][1];
  assign bus_a.wdata_0 = wdata_v[0][0]; assign bus_a.wdata_1 = wdata_v[0][1];
  assign bus_b.req_0 = req_v[1][0];   assign bus_b.req_1 = req_v[1][1];
  assign bus_b.we_0  = we_v[1][0];    assign bus_b.we_1  = we_v[1][1];
  assign bus_b.addr_0 = addr_v[1][0]; assign bus_b.addr_1 = addr_v[1][1];
  assign bus_b.wdata_0 = wdata_v[1][0]; assign bus_b.wdata_1 = wdata_v[1][1];

  assign gnt_v[0][0] = bus_a.gnt_0;       assign gnt_v[0][1] = bus_a.gnt_1;
  assign rvalid_v[0][0] = bus_a.rvalid_0; assign rvalid_v[0][1] = bus_a.rvalid_1;
  assign gnt_v[1][0] = bus_b.gnt_0;       assign gnt_v[1][1] = bus_b.gnt_1;
  assign rvalid_v[1][0] = bus_b.rvalid_0; assign rvalid_v[1][1] = bus_b.rvalid_1;
  assign rdata_v[0] = bus_a.rdata;  assign rdata_v[1] = bus_b.rdata;
  assign adm_v[0] = adm_a;          assign adm_v[1] = adm_b;
  assign dat_v[0] = dat_a;          assign dat_v[1] = dat_b;
  assign wren_v[0] = wren_a;        assign wren_v[1] = wren_b;

  // Syncram stand-ins: 1-stage and 3-stage read pipelines, write at the clock edge.
  bit [DATA_W-1:0] ram_a [DEPTH];
  bit [DATA_W-1:0] ram_b [DEPTH];
  logic [DATA_W-1:0] pb0, pb1;

  always @(posedge clock) begin
    if (wren_a) ram_a[adm_a] <= dat_a;
    q_a <= ram_a[adm_a];
  end

  always @(posedge clock) begin
    if (wren_b) ram_b[adm_b] <= dat_b;
    pb0 <= ram_b[adm_b];
    pb1 <= pb0;
    q_b <= pb1;
  end

  // Reference model: what the arbiter should show, derived from the transaction rules.
  bit [DATA_W-1:0]   ref_mem  [ND][DEPTH];
  int                cyc = 0;
  int                busy     [ND] = '{0, 0};
  int                last_port[ND] = '{1, 1};
  int                gnt_cyc  [ND] = '{-1, -1};
  int                gnt_port [ND] = '{0, 0};
  logic              exp_we   [ND] = '{1'b0, 1'b0};
  logic [ADDR_W-1:0] exp_addr [ND] = '{'0, '0};
  logic [DATA_W-1:0] exp_data [ND] = '{'0, '0};
  int                rv_cyc   [ND] = '{-1, -1};
  int                rv_port  [ND] = '{0, 0};
  logic [DATA_W-1:0] rv_val   [ND] = '{'0, '0};
  logic [DATA_W-1:0] exp_rdata[ND] = '{'0, '0};
  int                gnt_seen [ND][2];

  // Requester FIFOs: the head is presented with req until the port's grant is observed.
  txn_t fifo  [ND][2][16];
  int   f_head[ND][2];
  int   f_cnt [ND][2];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int pick(input int d, input logic r0, input logic r1);
    if (r0 && r1) return FIXED ? 0 : ((last_port[d] == 0) ? 1 : 0);
    return r0 ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int d, input int p, input logic w,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    fifo[d][p][(f_head[d][p] + f_cnt[d][p]) % 16] = '{we: w, addr: a, wdata: v};
    f_cnt[d][p]++;
  endtask

  task automatic post_all(input int p, input logic w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    for (int d = 0; d < ND; d++) post(d, p, w, a, v);
  endtask

  task automatic flush();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 2; p++) begin
        f_head[d][p] = 0;
        f_cnt[d][p]  = 0;
      end
  endtask

  task automatic drive_inputs();
    txn_t t;
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 2; p++) begin
        if (f_cnt[d][p] > 0) begin
          t = fifo[d][p][f_head[d][p]];
          req_v[d][p] = 1'b1; we_v[d][p] = t.we; addr_v[d][p] = t.addr; wdata_v[d][p] = t.wdata;
        end else begin
          req_v[d][p] = 1'b0; we_v[d][p] = 1'b0; addr_v[d][p] = '0; wdata_v[d][p] = '0;
        end
      end
  endtask

  // Decide what the arbiter does at the edge that ends cycle 'cyc'.
  task automatic model_edge(input int d);
    int w;
    if (reset) begin
      busy[d] = 0; last_port[d] = 1; gnt_cyc[d] = -1; rv_cyc[d] = -1;
      exp_we[d] = 1'b0; exp_addr[d] = '0; exp_data[d] = '0; exp_rdata[d] = '0;
    end else if (busy[d] > 0) begin
      busy[d]--;
    end else if (req_v[d][0] || req_v[d][1]) begin
      w = pick(d, req_v[d][0], req_v[d][1]);
      last_port[d] = w;
      gnt_cyc[d]   = cyc + 1;
      gnt_port[d]  = w;
      exp_we[d]    = we_v[d][w];
      exp_addr[d]  = addr_v[d][w];
      exp_data[d]  = wdata_v[d][w];
      if (we_v[d][w]) begin
        ref_mem[d][addr_v[d][w]] = wdata_v[d][w];
        busy[d] = 1;
      end else begin
        rv_cyc[d]  = cyc + lat_of(d) + 2;
        rv_port[d] = w;
        rv_val[d]  = ref_mem[d][addr_v[d][w]];
        busy[d]    = lat_of(d) + 1;
      end
    end
  endtask

  task automatic check_outputs(input int d);
    string pfx;
    pfx = $sformatf("dut%0d", d);
    if (cyc == rv_cyc[d]) exp_rdata[d] = rv_val[d];
    check({pfx, " gnt_0"},    gnt_v[d][0],    (cyc == gnt_cyc[d]) && (gnt_port[d] == 0));
    check({pfx, " gnt_1"},    gnt_v[d][1],    (cyc == gnt_cyc[d]) && (gnt_port[d] == 1));
    check({pfx, " rvalid_0"}, rvalid_v[d][0], (cyc == rv_cyc[d]) && (rv_port[d] == 0));
    check({pfx, " rvalid_1"}, rvalid_v[d][1], (cyc == rv_cyc[d]) && (rv_port[d] == 1));
    check({pfx, " wren"},     wren_v[d],      (cyc == gnt_cyc[d]) && exp_we[d]);
    check({pfx, " address_dmem"}, adm_v[d],   exp_addr[d]);
    check({pfx, " data"},     dat_v[d],       exp_data[d]);
    check({pfx, " rdata"},    rdata_v[d],     exp_rdata[d]);
    for (int p = 0; p < 2; p++) begin
      if (gnt_v[d][p] === 1'b1) gnt_seen[d][p] = cyc;
      if (rvalid_v[d][p] === 1'b1)
        check({pfx, " read latency"}, cyc - gnt_seen[d][p], lat_of(d) + 1);
    end
  endtask

  task automatic retire();
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 2; p++)
        if (gnt_v[d][p] === 1'b1 && f_cnt[d][p] > 0) begin
          f_head[d][p] = (f_head[d][p] + 1) % 16;
          f_cnt[d][p]--;
        end
  endtask

  task automatic tick();
    drive_inputs();
    for (int d = 0; d < ND; d++) model_edge(d);
    @(posedge clock);
    cyc++;
    @(negedge clock);
    for (int d = 0; d < ND; d++) check_outputs(d);
    retire();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    flush();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  int                rv_when [ND];
  logic [DATA_W-1:0] rv_dat  [ND];
  int                gseq    [ND][8];
  int                gn      [ND];
  int                g0_when [ND];
  int                rv0_cnt [ND];
  int                gt      [ND][3];
  logic [ADDR_W-1:0] ga      [ND][3];
  int                stray   [ND];

  initial begin
    // Reset, then a port-0 write followed by a port-1 read of the same word.
    do_reset(2);
    post_all(0, 1'b1, 12'h010, 32'hDEADBEEF);
    tick();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d first write gnt_0", d), gnt_v[d][0], 1'b1);
      check($sformatf("dut%0d first write wren", d), wren_v[d], 1'b1);
      check($sformatf("dut%0d first write address", d), adm_v[d], 12'h010);
    end
    tick();
    post_all(1, 1'b0, 12'h010, '0);
    tick();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d read gnt_1", d), gnt_v[d][1], 1'b1);
      rv_when[d] = -1;
      rv_dat[d]  = '0;
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      for (int d = 0; d < ND; d++)
        if (rvalid_v[d][1] === 1'b1 && rv_when[d] < 0) begin
          rv_when[d] = k;
          rv_dat[d]  = rdata_v[d];
        end
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d gnt_1 to rvalid_1", d), rv_when[d], lat_of(d) + 1);
      check($sformatf("dut%0d readback", d), rv_dat[d], 32'hDEADBEEF);
    end

    // Both ports hold read requests continuously.
    for (int k = 0; k < 4; k++) begin
      post_all(0, 1'b0, 12'(16 + k), '0);
      post_all(1, 1'b0, 12'(32 + k), '0);
    end
    for (int d = 0; d < ND; d++) begin
      gn[d] = 0;
      for (int k = 0; k < 8; k++) gseq[d][k] = -1;
    end
    for (int t = 0; t < 30; t++) begin
      tick();
      for (int d = 0; d < ND; d++)
        for (int p = 0; p < 2; p++)
          if (gnt_v[d][p] === 1'b1 && gn[d] < 8) begin
            gseq[d][gn[d]] = p;
            gn[d]++;
          end
    end
    for (int d = 0; d < ND; d++)
      for (int k = 0; k < 4; k++)
        check($sformatf("dut%0d grant order #%0d", d, k), gseq[d][k], FIXED ? 0 : (k % 2));
    do_reset(2);

    // Port-1 read; port 0 requests while the read is outstanding.
    post_all(1, 1'b0, 12'h005, '0);
    tick();
    tick();
    post_all(0, 1'b1, 12'h007, 32'h0BAD_F00D);
    for (int d = 0; d < ND; d++) begin
      rv_when[d] = -1; g0_when[d] = -1; rv0_cnt[d] = 0;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        if (rvalid_v[d][1] === 1'b1 && rv_when[d] < 0) rv_when[d] = k;
        if (gnt_v[d][0] === 1'b1 && g0_when[d] < 0) g0_when[d] = k;
        if (rvalid_v[d][0] !== 1'b0) rv0_cnt[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d rvalid_1 seen", d), rv_when[d] > 0, 1'b1);
      check($sformatf("dut%0d waiting gnt_0 after rvalid_1", d), g0_when[d] - rv_when[d], 1);
      check($sformatf("dut%0d rvalid_0 quiet", d), rv0_cnt[d], 0);
    end
    repeat (4) tick();

    // Reset lands while a port-1 read is waiting on the syncram.
    post_all(1, 1'b0, 12'h005, '0);
    tick();
    tick();
    reset = 1'b1;
    flush();
    tick();
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d post-reset gnt", d), {gnt_v[d][0], gnt_v[d][1]}, 2'b00);
      check($sformatf("dut%0d post-reset rvalid", d), {rvalid_v[d][0], rvalid_v[d][1]}, 2'b00);
      check($sformatf("dut%0d post-reset wren", d), wren_v[d], 1'b0);
      check($sformatf("dut%0d post-reset address", d), adm_v[d], '0);
      check($sformatf("dut%0d post-reset data", d), dat_v[d], '0);
      check($sformatf("dut%0d post-reset rdata", d), rdata_v[d], '0);
      rv0_cnt[d] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int d = 0; d < ND; d++)
        if (rvalid_v[d][0] !== 1'b0 || rvalid_v[d][1] !== 1'b0) rv0_cnt[d]++;
    end
    for (int d = 0; d < ND; d++)
      check($sformatf("dut%0d no rvalid after reset", d), rv0_cnt[d], 0);
    post_all(0, 1'b0, 12'h003, '0);
    post_all(1, 1'b0, 12'h004, '0);
    tick();
    for (int d = 0; d < ND; d++)
      check($sformatf("dut%0d tie after reset", d), {gnt_v[d][0], gnt_v[d][1]}, 2'b10);
    repeat (12) tick();

    // Back-to-back port-0 writes to addresses 1, 2, 3.
    for (int k = 0; k < 3; k++) post_all(0, 1'b1, 12'(k + 1), 32'hC0DE_0000 + 32'(k));
    for (int d = 0; d < ND; d++) begin
      gn[d] = 0; stray[d] = 0;
      for (int k = 0; k < 3; k++) begin gt[d][k] = -1; ga[d][k] = '0; end
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        if (gnt_v[d][0] === 1'b1 && gn[d] < 3) begin
          gt[d][gn[d]] = cyc;
          ga[d][gn[d]] = adm_v[d];
          gn[d]++;
        end
        if (wren_v[d] === 1'b1 && gnt_v[d][0] !== 1'b1) stray[d]++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      check($sformatf("dut%0d write spacing 1", d), gt[d][1] - gt[d][0], 2);
      check($sformatf("dut%0d write spacing 2", d), gt[d][2] - gt[d][1], 2);
      for (int k = 0; k < 3; k++)
        check($sformatf("dut%0d write address #%0d", d, k), ga[d][k], 12'(k + 1));
      check($sformatf("dut%0d wren outside gnt", d), stray[d], 0);
    end

    // Random traffic from both ports with occasional resets.
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        flush();
      end else begin
        for (int d = 0; d < ND; d++)
          for (int p = 0; p < 2; p++)
            if (f_cnt[d][p] == 0 && $urandom_range(0, 2) == 0)
              post(d, p, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), $urandom);
      end
      tick();
      reset = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
